// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: button synchronise/debounce, run/stop FSM and
// centisecond tick generation for the downstream digit counters.
module stopwatch_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 100,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_split,
  input  logic       btn_clear,
  output logic       clk_milisec,
  output logic       en,
  output logic       split,
  output logic       cnt_rst,
  output logic       split_active,
  output logic [1:0] state
);

  localparam int HALF = CLK_HZ / (2 * TICK_HZ);
  localparam int TW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(HALF - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t          st;
  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      deb;
  logic [2:0]      deb_d;
  logic [2:0]      press;
  logic [DW-1:0]   dcnt [3];
  logic [TW-1:0]   tcnt;
  logic            go;

  // Bit 0 start/stop, bit 1 split, bit 2 clear.
  assign raw   = {btn_clear, btn_split, btn_start_stop};
  assign press = deb & ~deb_d;
  assign go    = (st == IDLE) && press[0];
  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int unsigned i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  // Restart the tick phase on IDLE->RUN so the first tick edge is HALF cycles later.
  always_ff @(posedge clk) begin
    if (rst || go) begin
      tcnt        <= '0;
      clk_milisec <= 1'b0;
    end else if (tcnt == TICK_LAST) begin
      tcnt        <= '0;
      clk_milisec <= ~clk_milisec;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      en           <= 1'b0;
      split        <= 1'b0;
      cnt_rst      <= 1'b1;
      split_active <= 1'b0;
    end else begin
      split   <= 1'b0;
      cnt_rst <= 1'b0;
      unique case (st)
        IDLE: begin
          if (press[0]) begin
            st <= RUN;
            en <= 1'b1;
          end
        end
        RUN: begin
          if (press[1]) begin
            split        <= 1'b1;
            split_active <= ~split_active;
          end
          if (press[0]) begin
            st <= STOP;
            en <= 1'b0;
          end
        end
        STOP: begin
          if (press[2]) begin
            st           <= IDLE;
            cnt_rst      <= 1'b1;
            split_active <= 1'b0;
          end else begin
            if (press[0]) begin
              st <= RUN;
              en <= 1'b1;
            end
            if (press[1]) begin
              split        <= 1'b1;
              split_active <= ~split_active;
            end
          end
        end
        default: begin
          st <= IDLE;
          en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a cycle model of the button/FSM/tick
// behaviour checked every cycle, plus hand-computed literal checkpoints.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DEB     = 4;
  localparam int HALF    = CLK_HZ / (2 * TICK_HZ);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_split = 1'b0;
  logic       btn_clear = 1'b0;
  logic       clk_milisec;
  logic       en;
  logic       split;
  logic       cnt_rst;
  logic       split_active;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;

  stopwatch_ctrl #(
    .CLK_HZ(CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_start_stop(btn_start_stop),
    .btn_split(btn_split),
    .btn_clear(btn_clear),
    .clk_milisec(clk_milisec),
    .en(en),
    .split(split),
    .cnt_rst(cnt_rst),
    .split_active(split_active),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: raw samples history, accepted level per button after DEB
  // consecutive differing synchronized samples; an acceptance of a high
  // level acts on the FSM one edge later. Tick phase follows from t0.
  logic [2:0] hist[$];
  logic [2:0] acc = '0;
  logic [2:0] pending = '0;
  int         streak [3];
  int         k = 0;
  int         t0 = 0;
  int         mst = 0;
  int         msplit = 0;
  int         mcr = 0;
  int         msa = 0;

  always @(posedge clk) begin
    logic [2:0] act;
    logic [2:0] s;
    k++;
    if (rst) begin
      hist.delete();
      acc     = '0;
      pending = '0;
      for (int b = 0; b < 3; b++) streak[b] = 0;
      mst    = 0;
      msplit = 0;
      mcr    = 1;
      msa    = 0;
      t0     = k;
    end else begin
      act     = pending;
      pending = '0;
      msplit  = 0;
      mcr     = 0;
      case (mst)
        0: if (act[0]) begin mst = 1; t0 = k; end
        1: begin
          if (act[1]) begin msplit = 1; msa = 1 - msa; end
          if (act[0]) mst = 2;
        end
        default: begin
          if (act[2]) begin
            mst = 0; mcr = 1; msa = 0;
          end else begin
            if (act[0]) mst = 1;
            if (act[1]) begin msplit = 1; msa = 1 - msa; end
          end
        end
      endcase
      s = (hist.size() >= 2) ? hist[hist.size()-2] : 3'b000;
      for (int b = 0; b < 3; b++) begin
        if (s[b] != acc[b]) streak[b]++;
        else streak[b] = 0;
        if (streak[b] == DEB) begin
          acc[b]    = s[b];
          streak[b] = 0;
          if (s[b]) pending[b] = 1'b1;
        end
      end
      hist.push_back({btn_clear, btn_split, btn_start_stop});
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (k > 0) begin
      chk("state", int'(state), mst);
      chk("en", int'(en), (mst == 1) ? 1 : 0);
      chk("split", int'(split), msplit);
      chk("cnt_rst", int'(cnt_rst), mcr);
      chk("split_active", int'(split_active), msa);
      chk("clk_milisec", int'(clk_milisec), ((k - t0) / HALF) % 2);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(2);
    chk("lit_reset_cnt_rst", int'(cnt_rst), 1);
    chk("lit_reset_state", int'(state), 0);
    chk("lit_reset_en", int'(en), 0);
    chk("lit_reset_tick", int'(clk_milisec), 0);
    rst = 1'b0;
    cyc(1);
    chk("lit_post_reset_cnt_rst", int'(cnt_rst), 0);
    cyc(2);

    // Start: press acts on the 7th edge after it is first sampled.
    btn_start_stop = 1'b1;
    cyc(6);
    chk("lit_start_early", int'(state), 0);
    cyc(1);
    chk("lit_start_state", int'(state), 1);
    chk("lit_start_en", int'(en), 1);
    cyc(4);
    chk("lit_tick_e10", int'(clk_milisec), 0);
    cyc(1);
    chk("lit_tick_e11", int'(clk_milisec), 1);
    cyc(4);
    chk("lit_tick_e15", int'(clk_milisec), 1);
    cyc(1);
    chk("lit_tick_e16", int'(clk_milisec), 0);
    btn_start_stop = 1'b0;
    cyc(10);

    // Clear in RUN is ignored.
    btn_clear = 1'b1;
    cyc(10);
    chk("lit_clear_in_run", int'(state), 1);
    btn_clear = 1'b0;
    cyc(10);

    // Two splits in RUN.
    btn_split = 1'b1;
    cyc(6);
    chk("lit_split_early", int'(split), 0);
    cyc(1);
    chk("lit_split_pulse", int'(split), 1);
    chk("lit_split_active1", int'(split_active), 1);
    cyc(1);
    chk("lit_split_one_cycle", int'(split), 0);
    cyc(6);
    btn_split = 1'b0;
    cyc(10);
    btn_split = 1'b1;
    cyc(10);
    chk("lit_split_active0", int'(split_active), 0);
    btn_split = 1'b0;
    cyc(10);

    // Pause.
    btn_start_stop = 1'b1;
    cyc(7);
    chk("lit_stop_state", int'(state), 2);
    chk("lit_stop_en", int'(en), 0);
    btn_start_stop = 1'b0;
    cyc(10);

    // Split in STOP, then clear.
    btn_split = 1'b1;
    cyc(8);
    chk("lit_stop_split_active", int'(split_active), 1);
    btn_split = 1'b0;
    cyc(10);
    btn_clear = 1'b1;
    cyc(6);
    chk("lit_clear_early", int'(cnt_rst), 0);
    cyc(1);
    chk("lit_clear_state", int'(state), 0);
    chk("lit_clear_cnt_rst", int'(cnt_rst), 1);
    chk("lit_clear_split_active", int'(split_active), 0);
    cyc(1);
    chk("lit_clear_cnt_rst_end", int'(cnt_rst), 0);
    btn_clear = 1'b0;
    cyc(10);

    // Bounce: 3 high, 1 low, then held high.
    btn_start_stop = 1'b1;
    cyc(3);
    btn_start_stop = 1'b0;
    cyc(1);
    btn_start_stop = 1'b1;
    cyc(6);
    chk("lit_bounce_early", int'(state), 0);
    cyc(1);
    chk("lit_bounce_state", int'(state), 1);
    btn_start_stop = 1'b0;
    cyc(10);

    // Simultaneous start/stop + split in RUN.
    btn_start_stop = 1'b1;
    btn_split = 1'b1;
    cyc(7);
    chk("lit_sim_run_split", int'(split), 1);
    chk("lit_sim_run_state", int'(state), 2);
    btn_start_stop = 1'b0;
    btn_split = 1'b0;
    cyc(10);

    // Simultaneous clear + start/stop in STOP.
    btn_clear = 1'b1;
    btn_start_stop = 1'b1;
    cyc(7);
    chk("lit_sim_stop_state", int'(state), 0);
    chk("lit_sim_stop_en", int'(en), 0);
    chk("lit_sim_stop_cnt_rst", int'(cnt_rst), 1);
    btn_clear = 1'b0;
    btn_start_stop = 1'b0;
    cyc(10);

    // Reset mid-debounce discards the in-flight press.
    btn_start_stop = 1'b1;
    cyc(3);
    rst = 1'b1;
    btn_start_stop = 1'b0;
    cyc(1);
    chk("lit_midrst_cnt_rst", int'(cnt_rst), 1);
    chk("lit_midrst_state", int'(state), 0);
    rst = 1'b0;
    cyc(12);
    chk("lit_midrst_no_press", int'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Front-end control stage for the stopwatch digit counters; drives their clock, enable, split and reset inputs.
- Runs on the board system clock.
- Synchronizes and debounces three raw push-buttons (start/stop, split, clear).
- Runs a small run/stop state machine.
- Divides the system clock down to the 100 Hz centisecond tick that the counter block uses as its clock.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 100, tick frequency (one tick = one centisecond).
- DEB_CYCLES, 500_000, consecutive stable samples required to accept a button level (10 ms at 50 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- btn_start_stop  input  1  raw button, active-high, asynchronous to clk.
- btn_split  input  1  raw button, active-high, asynchronous to clk.
- btn_clear  input  1  raw button, active-high, asynchronous to clk.
- clk_milisec  output  1  tick square wave to the counter block.
- en  output  1  count enable, level.
- split  output  1  one-cycle pulse; the counter block toggles its frozen view on each rising edge.
- cnt_rst  output  1  counter clear, one-cycle pulse (active-high).
- split_active  output  1  mirror of the counter block's split-view toggle.
- state  output  2  current FSM state: 0 IDLE, 1 RUN, 2 STOP.

Behaviour:
- Reset: rst is synchronous, active-high, one clock. While rst is sampled high, all registers load their reset values on the clk edge.
  - Reset values: state=IDLE, en=0, split=0, split_active=0, clk_milisec=0, tick counter=0, synchronizers and debounced levels=0, debounce counters=0.
  - cnt_rst=1 during reset; it returns to 0 on the first edge with rst low. This clears the counters at power-up.
- Input path, per button:
  - 2-flop synchronizer.
  - Debounce counter counts edges where the synchronized level differs from the debounced level; it clears whenever the two are equal.
  - When the count reaches DEB_CYCLES-1 and the levels still differ, the debounced level takes the synchronized value and the counter clears.
  - Press = debounced rises (combinational compare against a 1-cycle delayed copy). Releases produce no action.
- Latency: a raw level held stable changes the FSM outputs on the (DEB_CYCLES+2)th rising clk edge after the first edge that samples the new level. A glitch shorter than DEB_CYCLES cycles produces no press.
- Tick generator:
  - HALF = CLK_HZ/(2*TICK_HZ), integer division, ceil(log2(HALF)) bits.
  - The counter wraps at HALF-1; clk_milisec toggles on each wrap. Period = 2*HALF clk cycles, 50% duty.
  - Free-running in every state.
  - On the IDLE->RUN transition, the counter and clk_milisec are forced to 0 in the same edge. The first counter rising edge therefore comes exactly HALF cycles after en rises.
- FSM (all transitions on clk edges, driven by press pulses):
  - IDLE: en=0. start_stop -> RUN. split and clear are ignored.
  - RUN: en=1. start_stop -> STOP. split -> split pulse, split_active toggles. clear is ignored.
  - STOP: en=0. start_stop -> RUN. split -> split pulse, split_active toggles. clear -> IDLE.
  - Entering IDLE from STOP: cnt_rst pulses for 1 cycle and split_active clears to 0 in the same edge.
- Simultaneous presses, same cycle:
  - In STOP, clear has priority: go to IDLE; start_stop and split are dropped.
  - In RUN, start_stop and split both act: a split pulse is issued and the state moves to STOP in the same edge.
  - In IDLE, start_stop acts and split is dropped.
- en is a registered decode of the next state, so it changes on the same edge as state.
- Reset asserted mid-operation (any state, mid-debounce, mid-tick): reset values apply on that edge, and in-flight presses are discarded.
- Holding a button held produces exactly one press.

Test Plan:
- Parameters CLK_HZ=1000, TICK_HZ=100, DEB_CYCLES=4, so HALF=5.
- Reset: rst high for 2 cycles, then low -> cnt_rst=1 during reset and 0 on the next edge; en=0, state=0, clk_milisec=0.
- Start: hold btn_start_stop high from edge E -> state=1 and en=1 at edge E+6. clk_milisec first rises at E+11 and then toggles every 5 cycles.
- Bounce: btn_start_stop high for 3 cycles, low for 1, then high -> no action until 4 consecutive stable synchronized samples; exactly one transition results.
- Split: in RUN press split -> split=1 for exactly 1 cycle, split_active=1. A second press -> split_active=0.
- Pause and clear: in RUN press start_stop -> state=2, en=0. Press clear -> state=0, cnt_rst=1 for 1 cycle, split_active=0. Clear pressed while in RUN -> no change.
- Simultaneous: in RUN, start_stop and split debounced in the same cycle -> one split pulse and state=2 on the same edge. In STOP, clear and start_stop together -> state=0 and en stays 0.
